// File: rtl/axi_lite_seq_pkg.sv
// Shared encodings for the AXI4-Lite write/read-back sequencer: FSM states,
// AXI response value and the error codes reported on err_code.
package axi_lite_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WB,
      ST_RA,
      ST_RD,
      ST_CHK,
      ST_FAIL,
      ST_FIN
   } seq_state_e;

   localparam logic [1:0] RESP_OKAY    = 2'b00;

   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_BRESP    = 3'd1;
   localparam logic [2:0] ERR_RRESP    = 3'd2;
   localparam logic [2:0] ERR_MISMATCH = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_hs_timeout.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// expiry in the TIMEOUT-th enabled cycle.
module axi_hs_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i && !expire_o) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/axi_lite_wrrd_sequencer.sv
// AXI4-Lite master that writes each table entry to consecutive slave addresses,
// reads it back and compares; stops at the first failure and reports it.
module axi_lite_wrrd_sequencer
   import axi_lite_seq_pkg::*;
#(
   parameter int  C_ADDR_W    = 32,
   parameter int  C_DATA_W    = 32,
   parameter int  NUM_VEC     = 4,
   parameter int  ADDR_STRIDE = 4,
   parameter int  TIMEOUT     = 1024,
   localparam int IDX_W       = idx_width(NUM_VEC)
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  start,
   input  logic [C_ADDR_W-1:0]   base_addr,
   input  logic                  vec_we,
   input  logic [IDX_W-1:0]      vec_idx,
   input  logic [C_DATA_W-1:0]   vec_data,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [2:0]            err_code,
   output logic [IDX_W-1:0]      fail_idx,
   output logic [C_ADDR_W-1:0]   M_AXI_AWADDR,
   output logic [2:0]            M_AXI_AWPROT,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [C_DATA_W-1:0]   M_AXI_WDATA,
   output logic [C_DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   output logic [C_ADDR_W-1:0]   M_AXI_ARADDR,
   output logic [2:0]            M_AXI_ARPROT,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [C_DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   seq_state_e                          state_q;
   logic [IDX_W-1:0]                    idx_q;
   logic [C_ADDR_W-1:0]                 base_q;
   logic [NUM_VEC-1:0][C_DATA_W-1:0]    tbl_q;
   logic                                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic [C_DATA_W-1:0]                 rdata_q;
   logic [1:0]                          rresp_q;
   logic                                busy_q, done_q, pass_q;
   logic [2:0]                          err_code_q, err_pend_q;
   logic [IDX_W-1:0]                    fail_idx_q;

   logic                                wr_done, in_wait, adv, tmo;
   logic [C_ADDR_W-1:0]                 addr;

   // Address only moves in CHK, so it is stable for the whole VALID window.
   assign addr = base_q + C_ADDR_W'(idx_q) * C_ADDR_W'(ADDR_STRIDE);

   assign M_AXI_AWADDR  = addr;
   assign M_AXI_ARADDR  = addr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WDATA   = tbl_q[idx_q];
   assign M_AXI_WSTRB   = {(C_DATA_W/8){1'b1}};
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_code = err_code_q;
   assign fail_idx = fail_idx_q;

   always_comb begin
      wr_done = (!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY);
      in_wait = 1'b0;
      adv     = 1'b0;
      case (state_q)
         ST_WR:   begin in_wait = 1'b1; adv = wr_done;       end
         ST_WB:   begin in_wait = 1'b1; adv = M_AXI_BVALID;  end
         ST_RA:   begin in_wait = 1'b1; adv = M_AXI_ARREADY; end
         ST_RD:   begin in_wait = 1'b1; adv = M_AXI_RVALID;  end
         default: ;
      endcase
   end

   // Cleared whenever a wait state is left, so every wait state starts from zero.
   axi_hs_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk_i    (ACLK),
      .rst_ni   (ARESETN),
      .clear_i  (!in_wait || adv),
      .enable_i (in_wait),
      .expire_o (tmo)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         tbl_q <= '0;
      end else if (state_q == ST_IDLE && vec_we && (int'(vec_idx) < NUM_VEC)) begin
         tbl_q[vec_idx] <= vec_data;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         base_q     <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_code_q <= ERR_NONE;
         err_pend_q <= ERR_NONE;
         fail_idx_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  base_q     <= base_addr;
                  idx_q      <= '0;
                  busy_q     <= 1'b1;
                  pass_q     <= 1'b0;
                  err_code_q <= ERR_NONE;
                  fail_idx_q <= '0;
                  awvalid_q  <= 1'b1;
                  wvalid_q   <= 1'b1;
                  state_q    <= ST_WR;
               end
            end
            ST_WR: begin
               if (M_AXI_AWREADY) awvalid_q <= 1'b0;
               if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
               if (wr_done) begin
                  bready_q <= 1'b1;
                  state_q  <= ST_WB;
               end else if (tmo) begin
                  awvalid_q  <= 1'b0;
                  wvalid_q   <= 1'b0;
                  err_pend_q <= ERR_TIMEOUT;
                  state_q    <= ST_FAIL;
               end
            end
            ST_WB: begin
               if (M_AXI_BVALID) begin
                  bready_q <= 1'b0;
                  if (M_AXI_BRESP != RESP_OKAY) begin
                     err_pend_q <= ERR_BRESP;
                     state_q    <= ST_FAIL;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= ST_RA;
                  end
               end else if (tmo) begin
                  bready_q   <= 1'b0;
                  err_pend_q <= ERR_TIMEOUT;
                  state_q    <= ST_FAIL;
               end
            end
            ST_RA: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RD;
               end else if (tmo) begin
                  // Abandoning VALID here breaks AXI on purpose; only a dead slave gets here.
                  arvalid_q  <= 1'b0;
                  err_pend_q <= ERR_TIMEOUT;
                  state_q    <= ST_FAIL;
               end
            end
            ST_RD: begin
               if (M_AXI_RVALID) begin
                  rready_q <= 1'b0;
                  rdata_q  <= M_AXI_RDATA;
                  rresp_q  <= M_AXI_RRESP;
                  state_q  <= ST_CHK;
               end else if (tmo) begin
                  rready_q   <= 1'b0;
                  err_pend_q <= ERR_TIMEOUT;
                  state_q    <= ST_FAIL;
               end
            end
            ST_CHK: begin
               if (rresp_q != RESP_OKAY) begin
                  err_pend_q <= ERR_RRESP;
                  state_q    <= ST_FAIL;
               end else if (rdata_q != tbl_q[idx_q]) begin
                  err_pend_q <= ERR_MISMATCH;
                  state_q    <= ST_FAIL;
               end else if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                  pass_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_FIN;
               end else begin
                  idx_q     <= idx_q + IDX_W'(1);
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  state_q   <= ST_WR;
               end
            end
            ST_FAIL: begin
               err_code_q <= err_pend_q;
               fail_idx_q <= idx_q;
               pass_q     <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               state_q    <= ST_FIN;
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_wrrd_sequencer.sv
// Directed bench: loopback AXI4-Lite slave with programmable delays and fault
// injection, driven and observed on the falling clock edge.
module tb_axi_lite_wrrd_sequencer;

   localparam int IW = 2;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b0;
   logic          start, vec_we;
   logic [31:0]   base_addr, vec_data;
   logic [IW-1:0] vec_idx;
   logic          busy, done, pass;
   logic [2:0]    err_code;
   logic [IW-1:0] fail_idx;
   logic [31:0]   M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]    M_AXI_WSTRB;
   logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
   logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic          M_AXI_RVALID, M_AXI_RREADY;

   always #5 ACLK = ~ACLK;

   axi_lite_wrrd_sequencer #(
      .C_ADDR_W(32), .C_DATA_W(32), .NUM_VEC(4), .ADDR_STRIDE(4), .TIMEOUT(16)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .base_addr(base_addr),
      .vec_we(vec_we), .vec_idx(vec_idx), .vec_data(vec_data),
      .busy(busy), .done(done), .pass(pass), .err_code(err_code), .fail_idx(fail_idx),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] get(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hxxxxxxxx;
   endfunction

   // slave configuration, written by the main process only
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   bit          rnd, ar_hold;
   int          bad_b_vec, bad_r_vec, bad_rr_vec;
   logic [1:0]  bad_bresp;
   logic [31:0] bad_rdata;

   // slave state, written by the slave process only
   bit          aw_seen, w_seen, ar_seen, b_pend, r_pend;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_cur, r_cur;
   int          aw_count, ar_count, arv_cyc;
   logic [31:0] last_wdata;
   logic [31:0] aw_log[$], w_log[$], ar_log[$];

   initial begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            b_cur = b_dly; r_cur = r_dly;
            aw_count = 0; ar_count = 0; arv_cyc = 0; last_wdata = 0;
            aw_log.delete(); w_log.delete(); ar_log.delete();
         end else begin
            // handshakes recorded last negedge completed at the posedge since
            if (b_pend) begin M_AXI_BVALID = 0; b_pend = 0; end
            if (r_pend) begin M_AXI_RVALID = 0; r_pend = 0; end
            if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
            if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_dly); w_cnt++; end
            else begin M_AXI_WREADY = 0; w_cnt = 0; end
            if (M_AXI_ARVALID) begin M_AXI_ARREADY = !ar_hold && (ar_cnt >= ar_dly); ar_cnt++; end
            else begin M_AXI_ARREADY = 0; ar_cnt = 0; end
            if (aw_seen && w_seen && !M_AXI_BVALID) begin
               if (b_cnt >= b_cur) begin
                  M_AXI_BVALID = 1;
                  M_AXI_BRESP  = (aw_count - 1 == bad_b_vec) ? bad_bresp : 2'b00;
                  aw_seen = 0; w_seen = 0; b_cnt = 0;
                  b_cur = rnd ? int'($urandom_range(0, 4)) : b_dly;
               end else b_cnt++;
            end
            if (ar_seen && !M_AXI_RVALID) begin
               if (r_cnt >= r_cur) begin
                  M_AXI_RVALID = 1;
                  M_AXI_RDATA  = (ar_count - 1 == bad_r_vec) ? bad_rdata : last_wdata;
                  M_AXI_RRESP  = (ar_count - 1 == bad_rr_vec) ? 2'b11 : 2'b00;
                  ar_seen = 0; r_cnt = 0;
                  r_cur = rnd ? int'($urandom_range(0, 4)) : r_dly;
               end else r_cnt++;
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
               aw_seen = 1; aw_count++; aw_log.push_back(M_AXI_AWADDR);
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
               w_seen = 1; last_wdata = M_AXI_WDATA; w_log.push_back(M_AXI_WDATA);
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 1;
            if (M_AXI_ARVALID) arv_cyc++;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               ar_seen = 1; ar_count++; ar_log.push_back(M_AXI_ARADDR);
            end
            if (M_AXI_RVALID && M_AXI_RREADY) r_pend = 1;
         end
      end
   end

   logic [31:0] tv[4];

   task automatic cfg_default();
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; rnd = 0; ar_hold = 0;
      bad_b_vec = -1; bad_r_vec = -1; bad_rr_vec = -1; bad_bresp = 2'b10; bad_rdata = 0;
   endtask

   task automatic do_reset();
      @(negedge ACLK); ARESETN = 0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1;
   endtask

   task automatic load_tbl();
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK); vec_we = 1; vec_idx = IW'(i); vec_data = tv[i];
      end
      @(negedge ACLK); vec_we = 0;
   endtask

   // poke: cycle at which start+vec_we(idx3) are pulsed mid-run (-1 none);
   // sw: write idx0 = 0x11112222 in the same cycle as start
   task automatic run(input logic [31:0] base, input int poke, input bit sw,
                      output int cyc, output logic busy1);
      @(negedge ACLK);
      base_addr = base; start = 1;
      if (sw) begin vec_we = 1; vec_idx = 0; vec_data = 32'h11112222; end
      @(negedge ACLK);
      start = 0; vec_we = 0;
      cyc = 1; busy1 = busy;
      while (done !== 1'b1 && cyc < 2000) begin
         if (cyc == poke) begin
            start = 1; vec_we = 1; vec_idx = 3; vec_data = 32'h12345678;
         end
         @(negedge ACLK);
         start = 0; vec_we = 0;
         cyc++;
      end
      if (done !== 1'b1) chk("done_wait", 64'(0), 64'(1));
   endtask

   int   cyc;
   logic b1;

   initial begin
      start = 0; base_addr = 0; vec_we = 0; vec_idx = 0; vec_data = 0;
      tv = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
      cfg_default();
      do_reset();
      chk("rst_out", 64'({busy, done, pass, err_code, fail_idx, M_AXI_AWVALID, M_AXI_WVALID,
                          M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
      chk("prot_strb", 64'({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}), 64'(10'h00F));

      // zero-wait slave, base 0, plus a start/vec_we pulse while busy
      load_tbl();
      run(32'h0, 7, 1'b0, cyc, b1);
      chk("zw_busy1", 64'(b1), 64'(1));
      chk("zw_cycles", 64'(cyc), 64'(21));
      chk("zw_pass", 64'({pass, err_code}), 64'(4'b1000));
      chk("zw_counts", 64'({aw_count, ar_count}), {32'd4, 32'd4});
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("zw_aw%0d", i), 64'(get(aw_log, i)), 64'(4 * i));
         chk($sformatf("zw_ar%0d", i), 64'(get(ar_log, i)), 64'(4 * i));
         chk($sformatf("zw_wd%0d", i), 64'(get(w_log, i)), 64'(tv[i]));
      end
      start = 1;  // same cycle as done: must be ignored
      @(negedge ACLK); start = 0;
      chk("zw_after_done", 64'({busy, done, pass}), 64'(3'b001));

      // delayed slave: AWREADY 3 cycles after WREADY, random B/R delays,
      // table write in the same cycle as start
      cfg_default(); aw_dly = 3; ar_dly = 2; rnd = 1; b_dly = 2; r_dly = 1;
      do_reset(); load_tbl();
      run(32'h0, -1, 1'b1, cyc, b1);
      chk("dly_pass", 64'({pass, err_code}), 64'(4'b1000));
      chk("dly_wd0", 64'(get(w_log, 0)), 64'(32'h11112222));
      chk("dly_aw3", 64'(get(aw_log, 3)), 64'(32'hC));
      chk("dly_wd3", 64'(get(w_log, 3)), 64'(32'hbeef0011));

      // read-data mismatch on vector 2
      cfg_default(); bad_r_vec = 2; bad_rdata = 32'hdead0010;
      do_reset(); load_tbl();
      run(32'h0, -1, 1'b0, cyc, b1);
      chk("mis_res", 64'({pass, err_code, fail_idx}), 64'({1'b0, 3'd3, 2'd2}));
      chk("mis_aw_cnt", 64'(aw_count), 64'(3));

      // BRESP error on vector 0
      cfg_default(); bad_b_vec = 0;
      do_reset(); load_tbl();
      run(32'h0, -1, 1'b0, cyc, b1);
      chk("bresp_res", 64'({pass, err_code, fail_idx}), 64'({1'b0, 3'd1, 2'd0}));
      chk("bresp_no_ar", 64'(ar_count), 64'(0));

      // RRESP error on vector 1
      cfg_default(); bad_rr_vec = 1;
      do_reset(); load_tbl();
      run(32'h0, -1, 1'b0, cyc, b1);
      chk("rresp_res", 64'({pass, err_code, fail_idx}), 64'({1'b0, 3'd2, 2'd1}));

      // ARREADY never asserted: timeout after 16 cycles in RA
      cfg_default(); ar_hold = 1;
      do_reset(); load_tbl();
      run(32'h0, -1, 1'b0, cyc, b1);
      chk("tmo_res", 64'({pass, err_code, fail_idx}), 64'({1'b0, 3'd4, 2'd0}));
      chk("tmo_arv_cyc", 64'(arv_cyc), 64'(16));
      chk("tmo_arvalid", 64'(M_AXI_ARVALID), 64'(0));

      // async reset while AWVALID is held, then a wrapping restart
      cfg_default(); aw_dly = 10;
      do_reset(); load_tbl();
      @(negedge ACLK); start = 1;
      @(negedge ACLK); start = 0;
      repeat (2) @(negedge ACLK);
      chk("mid_awvalid", 64'(M_AXI_AWVALID), 64'(1));
      #2 ARESETN = 0;
      #1 chk("mid_rst", 64'({busy, done, pass, err_code, M_AXI_AWVALID, M_AXI_WVALID,
                             M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
      cfg_default();
      do_reset(); load_tbl();
      run(32'hFFFFFFF8, -1, 1'b0, cyc, b1);
      chk("wrap_pass", 64'({pass, err_code}), 64'(4'b1000));
      chk("wrap_aw1", 64'(get(aw_log, 1)), 64'(32'hFFFFFFFC));
      chk("wrap_aw2", 64'(get(aw_log, 2)), 64'(32'h0));
      chk("wrap_ar3", 64'(get(ar_log, 3)), 64'(32'h4));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
